// File: rtl/pixel_fifo.sv
// pixel_fifo: first-word-fall-through pixel FIFO between a pixel source and a
// line buffer. It tracks pixel position within a frame on the pop side and
// keeps sticky overflow/underflow flags.
module pixel_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 3,
    parameter int DEPTH      = 16,
    parameter int IMG_WIDTH  = 6,
    parameter int IMG_HEIGHT = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           wr_en,
    input  logic [DATA_WIDTH*CHANNELS-1:0] wr_data,
    output logic                           full,
    input  logic                           fifo_read_en,
    output logic [DATA_WIDTH*CHANNELS-1:0] fifo_data,
    output logic                           fifo_empty,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           frame_done,
    output logic                           ovf_err,
    output logic                           udf_err
);

    localparam int PW    = DATA_WIDTH * CHANNELS;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int FRAME = IMG_WIDTH * IMG_HEIGHT;
    localparam int PIXW  = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [PIXW-1:0] LAST_PIX = PIXW'(FRAME - 1);

    logic [PW-1:0]   mem [DEPTH];
    logic [PW-1:0]   head;

    logic [AW-1:0]   wr_ptr_reg,  wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg,  rd_ptr_next;
    logic [CW-1:0]   count_reg,   count_next;
    logic [PIXW-1:0] pix_cnt_reg, pix_cnt_next;
    logic            frame_done_reg, frame_done_next;
    logic            ovf_reg, ovf_next;
    logic            udf_reg, udf_next;

    logic            wr_accept;
    logic            rd_accept;

    // Status flags come straight from the registered occupancy.
    assign full       = (count_reg == CW'(DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign count      = count_reg;
    assign frame_done = frame_done_reg;
    assign ovf_err    = ovf_reg;
    assign udf_err    = udf_reg;

    // Accept decisions use pre-edge full/empty, so no write-to-read bypass.
    assign wr_accept = wr_en        && !full       && !flush;
    assign rd_accept = fifo_read_en && !fifo_empty && !flush;

    // Storage: no reset, contents are hidden by the zeroed output while empty.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    assign head = mem[rd_ptr_reg];

    // Head pixel is forced to zero per channel while the FIFO is empty.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign fifo_data[gi*DATA_WIDTH +: DATA_WIDTH] =
                fifo_empty ? '0 : head[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Next-state for pointers, occupancy, frame position and error flags.
    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        count_next      = count_reg;
        pix_cnt_next    = pix_cnt_reg;
        frame_done_next = 1'b0;
        ovf_next        = ovf_reg;
        udf_next        = udf_reg;

        if (flush) begin
            wr_ptr_next  = '0;
            rd_ptr_next  = '0;
            count_next   = '0;
            pix_cnt_next = '0;
        end else begin
            if (wr_en && full) begin
                ovf_next = 1'b1;
            end
            if (fifo_read_en && fifo_empty) begin
                udf_next = 1'b1;
            end
            if (wr_accept) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (rd_accept) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
                if (pix_cnt_reg == LAST_PIX) begin
                    pix_cnt_next    = '0;
                    frame_done_next = 1'b1;
                end else begin
                    pix_cnt_next = pix_cnt_reg + PIXW'(1);
                end
            end
            if (wr_accept && !rd_accept) begin
                count_next = count_reg + CW'(1);
            end else if (rd_accept && !wr_accept) begin
                count_next = count_reg - CW'(1);
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            pix_cnt_reg    <= '0;
            frame_done_reg <= 1'b0;
            ovf_reg        <= 1'b0;
            udf_reg        <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            pix_cnt_reg    <= pix_cnt_next;
            frame_done_reg <= frame_done_next;
            ovf_reg        <= ovf_next;
            udf_reg        <= udf_next;
        end
    end

endmodule

// File: tb/tb_pixel_fifo.sv
// tb_pixel_fifo: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based reference model of the pixel FIFO.
module tb_pixel_fifo;

    localparam int DATA_WIDTH = 8;
    localparam int CHANNELS   = 3;
    localparam int DEPTH      = 16;
    localparam int IMG_WIDTH  = 6;
    localparam int IMG_HEIGHT = 6;
    localparam int PW         = DATA_WIDTH * CHANNELS;
    localparam int CW         = $clog2(DEPTH + 1);
    localparam int FRAME      = IMG_WIDTH * IMG_HEIGHT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [PW-1:0] wr_data = '0;
    logic          full;
    logic          fifo_read_en = 1'b0;
    logic [PW-1:0] fifo_data;
    logic          fifo_empty;
    logic [CW-1:0] count;
    logic          frame_done;
    logic          ovf_err;
    logic          udf_err;

    pixel_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .CHANNELS   (CHANNELS),
        .DEPTH      (DEPTH),
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .fifo_read_en (fifo_read_en),
        .fifo_data    (fifo_data),
        .fifo_empty   (fifo_empty),
        .count        (count),
        .frame_done   (frame_done),
        .ovf_err      (ovf_err),
        .udf_err      (udf_err)
    );

    always #5 clk = ~clk;

    // Reference model state: stored pixels in order, frame position, flags.
    logic [PW-1:0] q_m [$];
    int            pix_m;
    logic          fd_m;
    logic          ovf_m;
    logic          udf_m;

    int n_checks = 0;
    int n_pass   = 0;
    bit verbose  = 1'b1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        pix_m = 0;
        fd_m  = 1'b0;
        ovf_m = 1'b0;
        udf_m = 1'b0;
    endtask

    // One clock edge of behaviour, decided from the model's pre-edge state.
    task automatic model_step(input logic w, input logic r, input logic [PW-1:0] d, input logic f);
        bit was_full;
        bit was_empty;
        logic [PW-1:0] popped;
        was_full  = (q_m.size() == DEPTH);
        was_empty = (q_m.size() == 0);
        fd_m = 1'b0;
        if (f) begin
            q_m.delete();
            pix_m = 0;
        end else begin
            if (w && was_full)  ovf_m = 1'b1;
            if (r && was_empty) udf_m = 1'b1;
            if (r && !was_empty) begin
                popped = q_m.pop_front();
                if (pix_m == FRAME - 1) begin
                    fd_m  = 1'b1;
                    pix_m = 0;
                end else begin
                    pix_m++;
                end
            end
            if (w && !was_full) q_m.push_back(d);
        end
    endtask

    task automatic compare_all(input string pfx);
        logic [PW-1:0] exp_data;
        exp_data = (q_m.size() > 0) ? q_m[0] : '0;
        check({pfx, ".count"}, 64'(count), 64'(q_m.size()));
        check({pfx, ".full"}, 64'(full), 64'(q_m.size() == DEPTH));
        check({pfx, ".empty"}, 64'(fifo_empty), 64'(q_m.size() == 0));
        check({pfx, ".data"}, 64'(fifo_data), 64'(exp_data));
        check({pfx, ".frame_done"}, 64'(frame_done), 64'(fd_m));
        check({pfx, ".ovf"}, 64'(ovf_err), 64'(ovf_m));
        check({pfx, ".udf"}, 64'(udf_err), 64'(udf_m));
    endtask

    // Drive inputs for one edge, advance the model, sample 1 ns after the edge.
    task automatic cycle(input logic w, input logic r, input logic [PW-1:0] d, input logic f);
        wr_en        = w;
        fifo_read_en = r;
        wr_data      = d;
        flush        = f;
        @(posedge clk);
        model_step(w, r, d, f);
        #1;
        if (verbose)
            $display("t=%0t wr=%0b rd=%0b fl=%0b din=%06h | count=%0d dout=%06h fd=%0b ovf=%0b udf=%0b",
                     $time, w, r, f, d, count, fifo_data, frame_done, ovf_err, udf_err);
        compare_all("cyc");
        wr_en        = 1'b0;
        fifo_read_en = 1'b0;
        flush        = 1'b0;
    endtask

    // Asynchronous reset between edges; outputs must settle before the next edge.
    task automatic async_reset();
        wr_en = 1'b0;
        fifo_read_en = 1'b0;
        flush = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all("rst_async");
        @(posedge clk);
        #1;
        compare_all("rst_hold");
        rst = 1'b0;
    endtask

    // Push npix pixels base..base+npix-1 while popping whenever data is held.
    task automatic stream(input int npix, input int base, output int pulses);
        int   sent;
        int   exp_pop;
        logic w;
        logic r;
        sent    = 0;
        exp_pop = base;
        pulses  = 0;
        for (int c = 0; c < npix + 4; c++) begin
            w = (sent < npix);
            r = (q_m.size() > 0);
            if (r) begin
                check("pop_order", 64'(fifo_data), 64'(PW'(exp_pop)));
                exp_pop++;
            end
            cycle(w, r, PW'(base + sent), 1'b0);
            if (w) sent++;
            if (frame_done) pulses++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int wp;
        int rp;
        model_reset();

        // Reset state while rst is held.
        @(posedge clk);
        #1;
        compare_all("reset");
        rst = 1'b0;

        // Two writes, then one pop: head order and latency.
        cycle(1'b1, 1'b0, 24'h030201, 1'b0);
        check("req032.head1", 64'(fifo_data), 64'h030201);
        cycle(1'b1, 1'b0, 24'h060504, 1'b0);
        check("req032.count2", 64'(count), 64'd2);
        cycle(1'b0, 1'b1, '0, 1'b0);
        check("req032.head2", 64'(fifo_data), 64'h060504);
        check("req032.count1", 64'(count), 64'd1);

        // Fill to full, overflow attempt, then read+write while full.
        async_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, PW'(i + 100), 1'b0);
        check("req033.full", 64'(full), 64'd1);
        cycle(1'b1, 1'b0, 24'hBADBAD, 1'b0);
        check("req033.ovf", 64'(ovf_err), 64'd1);
        check("req033.count16", 64'(count), 64'd16);
        cycle(1'b1, 1'b1, 24'h777777, 1'b0);
        check("req033.count15", 64'(count), 64'd15);
        // Drain across the pointer wrap to confirm order.
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, '0, 1'b0);

        // Underflow and read+write while empty.
        async_reset();
        cycle(1'b0, 1'b1, '0, 1'b0);
        check("req034.udf", 64'(udf_err), 64'd1);
        cycle(1'b1, 1'b1, 24'h0000AA, 1'b0);
        check("req034.count1", 64'(count), 64'd1);
        check("req034.head", 64'(fifo_data), 64'h0000AA);

        // Two full frames streamed through.
        async_reset();
        stream(FRAME, 0, pulses);
        check("req035.pulses1", 64'(pulses), 64'd1);
        stream(FRAME, FRAME, pulses);
        check("req035.pulses2", 64'(pulses), 64'd1);

        // Partial traffic then flush with a concurrent write.
        async_reset();
        cycle(1'b0, 1'b1, '0, 1'b0);   // sets udf so flag preservation is visible
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, PW'(i + 200), 1'b0);
        for (int i = 0; i < 4; i++)  cycle(1'b0, 1'b1, '0, 1'b0);
        cycle(1'b1, 1'b1, 24'h123456, 1'b1);
        check("req036.count0", 64'(count), 64'd0);
        check("req036.empty", 64'(fifo_empty), 64'd1);
        check("req036.data0", 64'(fifo_data), 64'd0);
        check("req036.udf_kept", 64'(udf_err), 64'd1);
        stream(FRAME, 300, pulses);
        check("req036.pulses", 64'(pulses), 64'd1);

        // Async reset with count=7 and ovf set.
        async_reset();
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 1'b0, PW'(i), 1'b0);
        for (int i = 0; i < DEPTH - 7; i++) cycle(1'b0, 1'b1, '0, 1'b0);
        check("req037.pre_count", 64'(count), 64'd7);
        check("req037.pre_ovf", 64'(ovf_err), 64'd1);
        async_reset();
        check("req037.count", 64'(count), 64'd0);
        check("req037.ovf", 64'(ovf_err), 64'd0);

        // Randomized traffic with phases biased toward full and toward empty.
        verbose = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            case ((i / 400) % 4)
                0: begin wp = 80; rp = 30; end
                1: begin wp = 30; rp = 80; end
                2: begin wp = 60; rp = 60; end
                default: begin wp = 95; rp = 95; end
            endcase
            cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                  PW'($urandom), $urandom_range(0, 149) == 0);
            if (i % 1300 == 1299) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
